// File: rtl/fifo_umbral_pkg.sv
// Shared sizing for fifo_umbral, arbitro2 and their benches.
// DEPTH is derived so all users agree on the buffer size.
package fifo_umbral_pkg;

  localparam int DEF_WORD_SIZE = 12;
  localparam int DEF_ADDR_SIZE = 3;
  localparam int DEF_DEPTH     = 2 ** DEF_ADDR_SIZE;

endpackage

// File: rtl/fifo_umbral_memoria_fifo.sv
// Dual-port register array for fifo_umbral.
// Synchronous write, registered read that holds when idle.
module memoria_fifo
  import fifo_umbral_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [WORD_SIZE-1:0] rd_data
);

  logic [WORD_SIZE-1:0] r_mem [2**ADDR_SIZE];
  logic [WORD_SIZE-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Read sees the pre-write word when both ports hit one address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_rd_data <= '0;
    else if (rd_en) r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with live almost-full/almost-empty thresholds.
// Pointers, occupancy, flags and sticky error live here.
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 push,
  input  logic                 pop,
  input  logic [ADDR_SIZE:0]   umbral_alto,
  input  logic [ADDR_SIZE:0]   umbral_bajo,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 error,
  output logic [ADDR_SIZE:0]   count
);

  localparam logic [ADDR_SIZE:0]   CNT_FULL = (ADDR_SIZE+1)'(2**ADDR_SIZE);
  localparam logic [ADDR_SIZE:0]   CNT_ONE  = (ADDR_SIZE+1)'(1);
  localparam logic [ADDR_SIZE-1:0] PTR_ONE  = ADDR_SIZE'(1);

  logic [ADDR_SIZE-1:0] r_wr_ptr;
  logic [ADDR_SIZE-1:0] r_rd_ptr;
  logic [ADDR_SIZE:0]   r_count;
  logic                 r_valid;
  logic                 r_error;

  logic w_full;
  logic w_empty;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_err_set;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_rd_ok = pop && !w_empty;
  // A pop frees the slot, so push is accepted on a full FIFO too.
  assign w_wr_ok = push && (!w_full || pop);
  assign w_err_set = (push && w_full && !pop) || (pop && w_empty);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_valid <= w_rd_ok;
      if (w_err_set) r_error <= 1'b1;
      if (w_wr_ok)   r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_ok)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  memoria_fifo #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (w_wr_ok),
    .wr_addr(r_wr_ptr),
    .wr_data(data_in),
    .rd_en  (w_rd_ok),
    .rd_addr(r_rd_ptr),
    .rd_data(data_out)
  );

  assign valid_out    = r_valid;
  assign error        = r_error;
  assign count        = r_count;
  assign fifo_empty   = w_empty;
  assign fifo_full    = w_full;
  assign almost_full  = (r_count >= umbral_alto);
  assign almost_empty = (r_count <= umbral_bajo);

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed bench for fifo_umbral: fill, overflow, drain, wrap,
// empty push+pop, live thresholds and mid-cycle reset.
module tb_fifo_umbral;

  logic        clk;
  logic        reset;
  logic [11:0] data_in;
  logic        push;
  logic        pop;
  logic [3:0]  umbral_alto;
  logic [3:0]  umbral_bajo;
  logic [11:0] data_out;
  logic        valid_out;
  logic        fifo_empty;
  logic        fifo_full;
  logic        almost_full;
  logic        almost_empty;
  logic        error;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  fifo_umbral dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .push        (push),
    .pop         (pop),
    .umbral_alto (umbral_alto),
    .umbral_bajo (umbral_bajo),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .error       (error),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input int c);
    chk({tag, "/count"}, 32'(count), 32'(c));
    chk({tag, "/empty"}, 32'(fifo_empty), 32'(c == 0));
    chk({tag, "/full"}, 32'(fifo_full), 32'(c == 8));
    chk({tag, "/afull"}, 32'(almost_full), 32'(c >= int'(umbral_alto)));
    chk({tag, "/aempty"}, 32'(almost_empty), 32'(c <= int'(umbral_bajo)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    data_in = '0;
    umbral_alto = 4'd6;
    umbral_bajo = 4'd1;
    #1 reset = 1'b0;
    step();
    chk_flags("in_reset", 0);
    chk("in_reset/valid", 32'(valid_out), 0);
    chk("in_reset/err", 32'(error), 0);
    chk("in_reset/dout", 32'(data_out), 0);
    reset = 1'b1;
    step();
    chk_flags("post_reset", 0);
    chk("post_reset/valid", 32'(valid_out), 0);
    chk("post_reset/err", 32'(error), 0);

    for (int i = 1; i <= 8; i++) begin
      push = 1'b1;
      data_in = 12'(i);
      step();
      chk_flags($sformatf("fill%0d", i), i);
      chk($sformatf("fill%0d/err", i), 32'(error), 0);
      chk($sformatf("fill%0d/valid", i), 32'(valid_out), 0);
    end
    chk("fill/aempty_lit", 32'(almost_empty), 0);
    chk("fill/afull_lit", 32'(almost_full), 1);

    data_in = 12'hAAA;
    step();
    chk("ovf/err", 32'(error), 1);
    chk_flags("ovf", 8);
    push = 1'b0;

    for (int i = 1; i <= 8; i++) begin
      pop = 1'b1;
      step();
      chk($sformatf("drain%0d/dout", i), 32'(data_out), 32'(i));
      chk($sformatf("drain%0d/valid", i), 32'(valid_out), 1);
      chk_flags($sformatf("drain%0d", i), 8 - i);
    end
    pop = 1'b0;
    step();
    chk("idle/valid", 32'(valid_out), 0);
    chk("idle/dout_hold", 32'(data_out), 32'h008);
    chk_flags("idle", 0);

    for (int i = 1; i <= 8; i++) begin
      push = 1'b1;
      data_in = 12'(16 + i);
      step();
    end
    chk_flags("refill", 8);
    data_in = 12'h0F0;
    pop = 1'b1;
    step();
    chk_flags("full_pp", 8);
    chk("full_pp/dout", 32'(data_out), 32'h011);
    chk("full_pp/valid", 32'(valid_out), 1);
    push = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      step();
      chk($sformatf("wrap%0d/dout", i), 32'(data_out), 32'(16 + i));
      chk_flags($sformatf("wrap%0d", i), 9 - i);
    end
    step();
    chk("wrap/dout_f0", 32'(data_out), 32'h0F0);
    chk("wrap/valid_f0", 32'(valid_out), 1);
    chk_flags("wrap_end", 0);
    pop = 1'b0;
    chk("sticky/err", 32'(error), 1);

    reset = 1'b0;
    #1;
    chk("rst2/err", 32'(error), 0);
    chk("rst2/dout", 32'(data_out), 0);
    chk("rst2/valid", 32'(valid_out), 0);
    reset = 1'b1;
    step();

    push = 1'b1;
    pop = 1'b1;
    data_in = 12'h123;
    step();
    chk_flags("empty_pp", 1);
    chk("empty_pp/valid", 32'(valid_out), 0);
    chk("empty_pp/err", 32'(error), 1);
    push = 1'b0;
    step();
    chk("empty_pp2/dout", 32'(data_out), 32'h123);
    chk("empty_pp2/valid", 32'(valid_out), 1);
    chk_flags("empty_pp2", 0);
    pop = 1'b0;

    for (int i = 0; i < 4; i++) begin
      push = 1'b1;
      data_in = 12'(12'h300 + i);
      step();
    end
    push = 1'b0;
    step();
    chk_flags("four", 4);
    umbral_alto = 4'd4;
    umbral_bajo = 4'd4;
    #1;
    chk("thr/afull", 32'(almost_full), 1);
    chk("thr/aempty", 32'(almost_empty), 1);
    umbral_alto = 4'd5;
    umbral_bajo = 4'd3;
    #1;
    chk("thr2/afull", 32'(almost_full), 0);
    chk("thr2/aempty", 32'(almost_empty), 0);

    @(posedge clk);
    #3;
    umbral_alto = 4'd0;
    reset = 1'b0;
    #1;
    chk_flags("midrst", 0);
    chk("midrst/afull0", 32'(almost_full), 1);
    chk("midrst/err", 32'(error), 0);
    chk("midrst/valid", 32'(valid_out), 0);
    chk("midrst/dout", 32'(data_out), 0);
    umbral_alto = 4'd6;
    step();
    reset = 1'b1;
    pop = 1'b1;
    step();
    chk("after_rst/valid", 32'(valid_out), 0);
    chk("after_rst/err", 32'(error), 1);
    chk_flags("after_rst", 0);
    pop = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
